// File: rtl/hdr_parser_pkg.sv
// Shared types and constants for the programmable header parser.
//   - bus widths, header-buffer depth and header-id width
//   - packed layouts of node descriptors and transition entries
//   - parser FSM state encoding
package hdr_parser_pkg;

  localparam int BYTE_W      = 8;
  localparam int DATA_W      = 32;
  localparam int QUAD_W      = 64;
  localparam int KEY_W       = 16;
  localparam int HDR_MAX_LEN = 64;   // bytes captured into the header buffer
  localparam int HDR_IDX_W   = 6;    // index into the header buffer
  localparam int NUM_HEADERS = 16;   // nodes in the parse graph
  localparam int HID_W       = 4;    // header id width
  // Offsets are at most HDR_MAX_LEN and hdr_len at most 63, so 8 bits
  // hold off + hdr_len (and off + key_off + 1) without wrapping.
  localparam int ADDR_W      = 8;

  localparam logic [DATA_W-1:0] HDR_ABSENT = 32'hFFFF_FFFF;

  typedef logic [HID_W-1:0] hdr_id_t;

  typedef struct packed {
    logic [5:0]  hdr_len;     // [63:58]
    logic [5:0]  key_off;     // [57:52]
    logic        key_wide;    // [51]
    logic        is_end;      // [50]
    logic        dflt_valid;  // [49]
    hdr_id_t     dflt_next;   // [48:45]
    logic [44:0] rsvd;
  } node_t;

  typedef struct packed {
    logic             valid;    // [31]
    hdr_id_t          cur_hdr;  // [30:27]
    logic [KEY_W-1:0] key;      // [26:11]
    hdr_id_t          next_hdr; // [10:7]
    logic [6:0]       rsvd;
  } trans_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_PARSE,
    ST_SCAN,
    ST_DONE
  } state_t;

  // Number of bytes actually held in the header buffer for a packet of n bytes.
  function automatic logic [ADDR_W-1:0] cap_len(input logic [31:0] n);
    if (n >= 32'(HDR_MAX_LEN)) return ADDR_W'(HDR_MAX_LEN);
    return n[ADDR_W-1:0];
  endfunction

endpackage

// File: rtl/hdr_parser_trans_scan.sv
// Linear transition-table scanner: examines one entry per cycle.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   clear      restart the scan at entry 0 on the next cycle
//   en         advance to the next entry
//   cur_hdr    header id of the node being left
//   key        lookup key extracted from the current header
//   trans      transition table
//   hit        current entry matches (valid, cur_hdr and key equal)
//   next_hdr   next_hdr field of the current entry
//   exhausted  current entry is the last one in the table
module parse_trans_scan
  import hdr_parser_pkg::*;
#(
  parameter int MAX_TRANS = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              clear,
  input  logic                              en,
  input  hdr_id_t                           cur_hdr,
  input  logic [KEY_W-1:0]                  key,
  input  logic [MAX_TRANS-1:0][DATA_W-1:0]  trans,
  output logic                              hit,
  output hdr_id_t                           next_hdr,
  output logic                              exhausted
);

  localparam int IDX_W = (MAX_TRANS > 1) ? $clog2(MAX_TRANS) : 1;

  logic [IDX_W-1:0] idx_reg;
  trans_t           entry;
  logic             unused_rsvd;

  always_ff @(posedge clk) begin
    if (rst || clear) idx_reg <= '0;
    else if (en)      idx_reg <= idx_reg + 1'b1;
  end

  assign entry       = trans_t'(trans[idx_reg]);
  assign hit         = entry.valid && (entry.cur_hdr == cur_hdr) && (entry.key == key);
  assign next_hdr    = entry.next_hdr;
  assign exhausted   = (idx_reg == IDX_W'(MAX_TRANS - 1));
  assign unused_rsvd = ^entry.rsvd;

endmodule

// File: rtl/hdr_parser.sv
// Programmable header parser. Captures the first HDR_MAX_LEN bytes of a
// byte-serial packet, then walks a reloadable parse graph to find the byte
// offset of every header, and hands the result on with a start/ready handshake.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   in_valid_i/in_byte_i/in_last_i/in_ready_o   byte-serial packet input
//   start_o / ready_i             result valid (held) / consumer done
//   pkt_hdr_o                     captured header bytes, zero past captured length
//   parsed_hdrs_o                 offset of each header or HDR_ABSENT
//   pkt_len_o                     saturating count of packet bytes
//   parse_err_o                   truncated header, revisited node or loop
//   mod_start_i/mod_nodes_i/mod_trans_i   table reload (accepted in IDLE only)
module hdr_parser
  import hdr_parser_pkg::*;
#(
  parameter int MAX_TRANS = 16,
  parameter int FIRST_HDR = 0,
  parameter int LEN_W     = 16
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   in_valid_i,
  input  logic [BYTE_W-1:0]                      in_byte_i,
  input  logic                                   in_last_i,
  output logic                                   in_ready_o,
  output logic                                   start_o,
  input  logic                                   ready_i,
  output logic [HDR_MAX_LEN-1:0][BYTE_W-1:0]     pkt_hdr_o,
  output logic [NUM_HEADERS-1:0][DATA_W-1:0]     parsed_hdrs_o,
  output logic [LEN_W-1:0]                       pkt_len_o,
  output logic                                   parse_err_o,
  input  logic                                   mod_start_i,
  input  logic [NUM_HEADERS-1:0][QUAD_W-1:0]     mod_nodes_i,
  input  logic [MAX_TRANS-1:0][DATA_W-1:0]       mod_trans_i
);

  state_t                               state_reg, state_next;
  logic                                 in_ready_reg;
  logic [NUM_HEADERS-1:0][QUAD_W-1:0]   nodes_reg;
  logic [MAX_TRANS-1:0][DATA_W-1:0]     trans_reg;
  logic [BYTE_W-1:0]                    hdr_buf_reg [HDR_MAX_LEN];
  logic [NUM_HEADERS-1:0][DATA_W-1:0]   parsed_reg;
  logic [NUM_HEADERS-1:0]               visited_reg;
  logic [LEN_W-1:0]                     pkt_len_reg;
  logic [ADDR_W-1:0]                    cap_reg;
  logic [ADDR_W-1:0]                    off_reg;
  hdr_id_t                              cur_reg;
  logic                                 err_reg;

  logic              accept, pkt_begin, node_fail, take_dflt;
  logic [LEN_W-1:0]  len_inc;
  node_t             cur_node;
  logic [ADDR_W-1:0] off_next, key_pos0, key_pos1;
  logic [BYTE_W-1:0] key_b0, key_b1;
  logic [KEY_W-1:0]  key;
  logic              scan_hit, scan_exh;
  hdr_id_t           scan_next;
  logic              unused_rsvd;

  assign accept    = in_valid_i & in_ready_reg;
  // A table load in IDLE takes priority over a new packet.
  assign pkt_begin = (state_reg == ST_IDLE) && !mod_start_i && accept;
  assign len_inc   = (pkt_len_reg == '1) ? pkt_len_reg : pkt_len_reg + LEN_W'(1);

  assign cur_node    = node_t'(nodes_reg[cur_reg]);
  assign unused_rsvd = ^cur_node.rsvd;
  assign off_next    = off_reg + ADDR_W'(cur_node.hdr_len);
  assign node_fail   = visited_reg[cur_reg] || (off_next > cap_reg);

  // Key bytes beyond the buffer read as zero.
  assign key_pos0 = off_reg + ADDR_W'(cur_node.key_off);
  assign key_pos1 = key_pos0 + ADDR_W'(1);
  assign key_b0   = (key_pos0 < ADDR_W'(HDR_MAX_LEN)) ? hdr_buf_reg[key_pos0[HDR_IDX_W-1:0]] : '0;
  assign key_b1   = (key_pos1 < ADDR_W'(HDR_MAX_LEN)) ? hdr_buf_reg[key_pos1[HDR_IDX_W-1:0]] : '0;
  assign key      = cur_node.key_wide ? {key_b0, key_b1} : {8'h00, key_b0};

  assign take_dflt = scan_exh && !scan_hit && cur_node.dflt_valid;

  parse_trans_scan #(.MAX_TRANS(MAX_TRANS)) u_scan (
    .clk       (clk),
    .rst       (rst),
    .clear     (state_reg == ST_PARSE),
    .en        (state_reg == ST_SCAN),
    .cur_hdr   (cur_reg),
    .key       (key),
    .trans     (trans_reg),
    .hit       (scan_hit),
    .next_hdr  (scan_next),
    .exhausted (scan_exh)
  );

  always_ff @(posedge clk) begin
    if (rst) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (pkt_begin) state_next = in_last_i ? ST_PARSE : ST_LOAD;
      ST_LOAD:  if (accept && in_last_i) state_next = ST_PARSE;
      ST_PARSE: begin
        if (node_fail || cur_node.is_end) state_next = ST_DONE;
        else                              state_next = ST_SCAN;
      end
      ST_SCAN: begin
        if (scan_hit || take_dflt) state_next = ST_PARSE;
        else if (scan_exh)         state_next = ST_DONE;
      end
      ST_DONE:  if (ready_i) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Byte capture: byte 0 on packet start, later bytes at their own index.
  // Bytes at index HDR_MAX_LEN or later never match a slot and are dropped.
  for (genvar gi = 0; gi < HDR_MAX_LEN; gi++) begin : g_hdr
    always_ff @(posedge clk) begin
      if (rst)
        hdr_buf_reg[gi] <= '0;
      else if (pkt_begin)
        hdr_buf_reg[gi] <= (gi == 0) ? in_byte_i : '0;
      else if (state_reg == ST_LOAD && accept && pkt_len_reg == LEN_W'(gi))
        hdr_buf_reg[gi] <= in_byte_i;
    end
    assign pkt_hdr_o[gi] = hdr_buf_reg[gi];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      in_ready_reg <= 1'b0;
      nodes_reg    <= '0;
      trans_reg    <= '0;
      parsed_reg   <= {NUM_HEADERS{HDR_ABSENT}};
      visited_reg  <= '0;
      pkt_len_reg  <= '0;
      cap_reg      <= '0;
      off_reg      <= '0;
      cur_reg      <= '0;
      err_reg      <= 1'b0;
    end else begin
      in_ready_reg <= (state_next == ST_IDLE) || (state_next == ST_LOAD);
      case (state_reg)
        ST_IDLE: begin
          if (mod_start_i) begin
            nodes_reg <= mod_nodes_i;
            trans_reg <= mod_trans_i;
          end else if (accept) begin
            parsed_reg  <= {NUM_HEADERS{HDR_ABSENT}};
            visited_reg <= '0;
            err_reg     <= 1'b0;
            pkt_len_reg <= LEN_W'(1);
            cap_reg     <= ADDR_W'(1);
            cur_reg     <= hdr_id_t'(FIRST_HDR);
            off_reg     <= '0;
          end
        end
        ST_LOAD: begin
          if (accept) begin
            pkt_len_reg <= len_inc;
            if (in_last_i) cap_reg <= cap_len(32'(len_inc));
          end
        end
        ST_PARSE: begin
          if (node_fail) begin
            err_reg <= 1'b1;
          end else begin
            parsed_reg[cur_reg]  <= DATA_W'(off_reg);
            visited_reg[cur_reg] <= 1'b1;
          end
        end
        ST_SCAN: begin
          if (scan_hit) begin
            cur_reg <= scan_next;
            off_reg <= off_next;
          end else if (take_dflt) begin
            cur_reg <= cur_node.dflt_next;
            off_reg <= off_next;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready_o    = in_ready_reg;
  assign start_o       = (state_reg == ST_DONE);
  assign parsed_hdrs_o = parsed_reg;
  assign pkt_len_o     = pkt_len_reg;
  assign parse_err_o   = err_reg;

endmodule

// File: tb/tb_hdr_parser.sv
// Self-checking bench for hdr_parser: table of directed Eth/IPv4 vectors,
// handshake and reset sequences, then randomized graphs against a
// high-level reference walk of the parse graph.
module tb_hdr_parser;
  import hdr_parser_pkg::*;

  localparam int MT = 16;
  localparam int FH = 0;
  localparam int LW = 16;
  localparam logic [31:0] ABS = 32'hFFFF_FFFF;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid_i = 1'b0;
  logic [7:0] in_byte_i = '0;
  logic in_last_i = 1'b0;
  logic in_ready_o, start_o, parse_err_o;
  logic ready_i = 1'b0;
  logic [63:0][7:0] pkt_hdr_o;
  logic [15:0][31:0] parsed_hdrs_o;
  logic [LW-1:0] pkt_len_o;
  logic mod_start_i = 1'b0;
  logic [15:0][63:0] mod_nodes_i = '0;
  logic [MT-1:0][31:0] mod_trans_i = '0;

  hdr_parser #(.MAX_TRANS(MT), .FIRST_HDR(FH), .LEN_W(LW)) dut (
    .clk(clk), .rst(rst),
    .in_valid_i(in_valid_i), .in_byte_i(in_byte_i), .in_last_i(in_last_i), .in_ready_o(in_ready_o),
    .start_o(start_o), .ready_i(ready_i),
    .pkt_hdr_o(pkt_hdr_o), .parsed_hdrs_o(parsed_hdrs_o), .pkt_len_o(pkt_len_o), .parse_err_o(parse_err_o),
    .mod_start_i(mod_start_i), .mod_nodes_i(mod_nodes_i), .mod_trans_i(mod_trans_i)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0]        pkt [256];
  int                plen;
  logic [15:0][63:0] tb_nodes;
  logic [MT-1:0][31:0] tb_trans;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=timeout required=event", name);
  endtask

  function automatic logic [63:0] mk_node(int len, int koff, bit wide, bit is_end, bit dv, int dn);
    return {6'(len), 6'(koff), wide, is_end, dv, 4'(dn), 45'b0};
  endfunction

  function automatic logic [31:0] mk_trans(bit v, int cur, logic [15:0] key, int nxt);
    return {v, 4'(cur), key, 4'(nxt), 7'b0};
  endfunction

  function automatic logic [7:0] hb(int x);
    return (x < plen && x < 64) ? pkt[x] : 8'h00;
  endfunction

  function automatic logic [63:0][7:0] exp_hdr();
    logic [63:0][7:0] h;
    for (int i = 0; i < 64; i++) h[i] = hb(i);
    return h;
  endfunction

  // Reference: walk the graph node by node; latency is one cycle per node,
  // one per transition entry examined, plus one to reach the result.
  function automatic void model(output logic [15:0][31:0] ep, output bit ee, output int el);
    int cap, off, cur, hl, kp, found;
    logic [15:0] key;
    bit [15:0] vis;
    logic [63:0] nd;
    logic [31:0] tr;
    cap = (plen < 64) ? plen : 64;
    ep = '1; ee = 0; el = 0; vis = '0; cur = FH; off = 0;
    for (int step = 0; step < 64; step++) begin
      nd = tb_nodes[cur];
      hl = int'(nd[63:58]);
      el++;
      if (vis[cur] || off + hl > cap) begin ee = 1; break; end
      ep[cur] = 32'(off);
      vis[cur] = 1'b1;
      if (nd[50]) break;
      kp = off + int'(nd[57:52]);
      key = nd[51] ? {hb(kp), hb(kp + 1)} : {8'h00, hb(kp)};
      found = -1;
      for (int j = 0; j < MT; j++) begin
        tr = tb_trans[j];
        if (found < 0 && tr[31] && int'(tr[30:27]) == cur && tr[26:11] == key) found = j;
      end
      if (found >= 0) begin
        el += found + 1;
        tr = tb_trans[found];
        cur = int'(tr[10:7]);
        off += hl;
      end else begin
        el += MT;
        if (nd[49]) begin cur = int'(nd[48:45]); off += hl; end
        else break;
      end
    end
    el++;
  endfunction

  task automatic setup_eth(input bit loop);
    tb_nodes = '0;
    tb_trans = '0;
    tb_nodes[0] = mk_node(14, 12, 1, 0, 0, 0);
    tb_nodes[1] = mk_node(20, 0, 0, 1, 0, 0);
    tb_trans[0] = mk_trans(1, 0, 16'h0800, loop ? 0 : 1);
  endtask

  task automatic build_pkt(input int len, input logic [15:0] etype);
    plen = len;
    for (int i = 0; i < len; i++) pkt[i] = 8'(i * 7 + 3);
    if (len > 13) begin pkt[12] = etype[15:8]; pkt[13] = etype[7:0]; end
  endtask

  task automatic load_tables();
    mod_nodes_i = tb_nodes;
    mod_trans_i = tb_trans;
    mod_start_i = 1'b1;
    @(posedge clk); #1;
    mod_start_i = 1'b0;
  endtask

  task automatic feed_bytes();
    int w;
    for (int i = 0; i < plen; i++) begin
      in_valid_i = 1'b1; in_byte_i = pkt[i]; in_last_i = (i == plen - 1);
      w = 0;
      while (!in_ready_o && w < 50) begin @(posedge clk); #1; w++; end
      if (w == 50) fail_now("in_ready_wait");
      @(posedge clk); #1;
    end
    in_valid_i = 1'b0; in_last_i = 1'b0;
  endtask

  // lat = cycles from the in_last cycle to the first start_o cycle.
  task automatic wait_start(output int lat);
    int w = 0;
    while (!start_o && w < 500) begin @(posedge clk); #1; w++; end
    if (!start_o) fail_now("start_wait");
    lat = w + 1;
  endtask

  task automatic release_result(input string tag);
    ready_i = 1'b1;
    @(posedge clk); #1;
    ready_i = 1'b0;
    check({tag, ".start_drop"}, start_o, 0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, ".start"}, start_o, 0);
    check({tag, ".in_ready"}, in_ready_o, 0);
    check({tag, ".err"}, parse_err_o, 0);
    check({tag, ".len"}, pkt_len_o, 0);
    check({tag, ".hdr"}, pkt_hdr_o, 0);
    check({tag, ".parsed"}, parsed_hdrs_o, {16{ABS}});
  endtask

  typedef struct {
    int          len;
    logic [15:0] etype;
    bit          loop;
    logic [31:0] p0;
    logic [31:0] p1;
    bit          err;
    int          lat;
  } vec_t;

  vec_t vecs [7];

  initial begin
    int lat, el;
    bit ee;
    logic [15:0][31:0] ep;
    string tag;

    vecs[0] = '{60,  16'h0800, 1'b0, 32'd0, 32'd14, 1'b0, 4};
    vecs[1] = '{60,  16'h86DD, 1'b0, 32'd0, ABS,    1'b0, MT + 2};
    vecs[2] = '{20,  16'h0800, 1'b0, 32'd0, ABS,    1'b1, 4};
    vecs[3] = '{60,  16'h0800, 1'b1, 32'd0, ABS,    1'b1, 4};
    vecs[4] = '{13,  16'h0800, 1'b0, ABS,   ABS,    1'b1, 2};
    vecs[5] = '{34,  16'h0800, 1'b0, 32'd0, 32'd14, 1'b0, 4};
    vecs[6] = '{100, 16'h0800, 1'b0, 32'd0, 32'd14, 1'b0, 4};

    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed vectors
    for (int v = 0; v < 7; v++) begin
      tag = $sformatf("vec%0d", v);
      setup_eth(vecs[v].loop);
      load_tables();
      build_pkt(vecs[v].len, vecs[v].etype);
      feed_bytes();
      wait_start(lat);
      check({tag, ".p0"}, parsed_hdrs_o[0], vecs[v].p0);
      check({tag, ".p1"}, parsed_hdrs_o[1], vecs[v].p1);
      check({tag, ".rest"}, parsed_hdrs_o[15:2], {14{ABS}});
      check({tag, ".err"}, parse_err_o, vecs[v].err);
      check({tag, ".len"}, pkt_len_o, vecs[v].len);
      check({tag, ".hdr"}, pkt_hdr_o, exp_hdr());
      check({tag, ".lat"}, lat, vecs[v].lat);
      release_result(tag);
      $display("vec%0d len=%0d etype=%h err=%0d lat=%0d", v, vecs[v].len, vecs[v].etype, parse_err_o, lat);
    end

    // Handshake hold, and table load ignored outside IDLE
    setup_eth(0);
    load_tables();
    build_pkt(60, 16'h0800);
    feed_bytes();
    wait_start(lat);
    for (int c = 0; c < 10; c++) begin
      mod_nodes_i = '0; mod_trans_i = '0;
      mod_start_i = (c == 3);
      @(posedge clk); #1;
      check($sformatf("hold%0d.start", c), start_o, 1);
      check($sformatf("hold%0d.in_ready", c), in_ready_o, 0);
    end
    mod_start_i = 1'b0;
    release_result("hold");
    check("hold.kept_p1", parsed_hdrs_o[1], 32'd14);
    feed_bytes();
    wait_start(lat);
    check("after_hold.p1", parsed_hdrs_o[1], 32'd14);
    check("after_hold.lat", lat, 4);
    release_result("after_hold");
    $display("handshake sequence lat=%0d", lat);

    // Reset during LOAD
    for (int i = 0; i < 5; i++) begin
      in_valid_i = 1'b1; in_byte_i = 8'hA0 + 8'(i); in_last_i = 1'b0;
      @(posedge clk); #1;
    end
    in_valid_i = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    check_reset_vals("rst_load");
    rst = 1'b0;
    @(posedge clk); #1;
    setup_eth(0);
    load_tables();
    build_pkt(60, 16'h0800);
    feed_bytes();
    wait_start(lat);
    check("post_rst_load.p1", parsed_hdrs_o[1], 32'd14);
    check("post_rst_load.hdr", pkt_hdr_o, exp_hdr());
    release_result("post_rst_load");
    $display("reset in LOAD then packet p1=%0d", parsed_hdrs_o[1]);

    // Reset during SCAN
    build_pkt(60, 16'h86DD);
    feed_bytes();
    repeat (5) begin @(posedge clk); #1; end
    check("scan.in_ready", in_ready_o, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    check_reset_vals("rst_scan");
    rst = 1'b0;
    @(posedge clk); #1;
    setup_eth(0);
    load_tables();
    build_pkt(60, 16'h0800);
    feed_bytes();
    wait_start(lat);
    check("post_rst_scan.p1", parsed_hdrs_o[1], 32'd14);
    check("post_rst_scan.len", pkt_len_o, 60);
    release_result("post_rst_scan");
    $display("reset in SCAN then packet p1=%0d", parsed_hdrs_o[1]);

    // Randomized parse graphs against the reference walk
    for (int r = 0; r < 40; r++) begin
      tag = $sformatf("rnd%0d", r);
      tb_nodes = '0;
      tb_trans = '0;
      for (int n = 0; n < 6; n++)
        tb_nodes[n] = mk_node($urandom_range(0, 24), $urandom_range(0, 20), 1'($urandom_range(0, 1)),
                              $urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)), $urandom_range(0, 5));
      for (int t = 0; t < MT; t++)
        tb_trans[t] = mk_trans($urandom_range(0, 3) != 0, $urandom_range(0, 5),
                               16'($urandom_range(0, 3)), $urandom_range(0, 5));
      load_tables();
      plen = $urandom_range(1, 90);
      for (int i = 0; i < plen; i++) pkt[i] = 8'($urandom_range(0, 3));
      model(ep, ee, el);
      feed_bytes();
      wait_start(lat);
      check({tag, ".parsed"}, parsed_hdrs_o, ep);
      check({tag, ".err"}, parse_err_o, ee);
      check({tag, ".len"}, pkt_len_o, plen);
      check({tag, ".hdr"}, pkt_hdr_o, exp_hdr());
      check({tag, ".lat"}, lat, el);
      release_result(tag);
      $display("rnd%0d len=%0d err=%0d lat=%0d exp_lat=%0d", r, plen, parse_err_o, lat, el);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
